fifo_wr_arb: RTL and testbench

- Round-robin write arbiter that shares one FIFO write port between NREQ requesters.
- Drives the FIFO client-side din/wen and observes full; the read side is untouched.
- Holds a one-entry output register so the FIFO write path is registered and full-backpressure never combinationally reaches requesters' data.
- Sits between the producer blocks and the FIFO client interface.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arb.sv | 97 +++++++++
 tb/tb_fifo_wr_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared helpers for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  localparam int unsigned MaxNreq = 16;

  // Index width for n sources; never narrower than one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: first set bit at or after last+1, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          any
);

  logic [2*N-1:0] rot;
  int unsigned    s;

  always_comb begin
    win = '0;
    any = |req;
    s   = 0;
    // Doubling the vector turns the wrap-around search into a plain shift.
    rot = {req, req} >> ({1'b0, last} + 1'b1);
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (rot[j]) begin
        s = int'(last) + 1 + j;
        if (s >= N) s = s - N;
        win = IW'(s);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one registered FIFO write port between NREQ producers.
// Define FIFO_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [DW-1:0]             fifo_din,
  output logic                      fifo_wen,
  input  logic                      fifo_full,
  output logic [idw(NREQ)-1:0]      grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*CNTW-1:0]      grant_cnt
`endif
);

  localparam int unsigned IW = idw(NREQ);

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] data;
    logic [IW-1:0] src;
  } out_stage_t;

  out_stage_t        out_q;
  logic [IW-1:0]     last_q;
  logic [IW-1:0]     win;
  logic              any;
  logic              can_acc;
  logic              hs;
  logic [NREQ*DW-1:0] shifted;
  logic [DW-1:0]     win_data;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req  (req_valid),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    fifo_wen  = out_q.vld && !fifo_full;
    fifo_din  = out_q.data;
    grant_id  = out_q.src;
    // Accept when the stage is empty or is being drained this cycle.
    can_acc   = !out_q.vld || !fifo_full;
    hs        = any && can_acc;
    req_ready = hs ? (NREQ'(1) << win) : '0;
    shifted   = req_data >> (DW * 32'(win));
    win_data  = shifted[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      last_q <= IW'(NREQ - 1);
    end else if (hs) begin
      out_q.vld  <= 1'b1;
      out_q.data <= win_data;
      out_q.src  <= win;
      last_q     <= win;
    end else if (fifo_wen) begin
      out_q.vld <= 1'b0;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CNTW-1:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREQ); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (hs && win == IW'(i) && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < int'(NREQ); i++) grant_cnt[i*CNTW +: CNTW] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: vector table, directed corners, random vs. model.
module tb_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int CNTW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        fifo_din;
  logic                 fifo_wen;
  logic                 fifo_full;
  logic [1:0]           grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*CNTW-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .DW   (DW),
    .NREQ (NREQ),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_din  (fifo_din),
    .fifo_wen  (fifo_wen),
    .fifo_full (fifo_full),
`ifdef FIFO_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .grant_id  (grant_id)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the word waiting for the FIFO and who was served last.
  bit          m_held;
  logic [31:0] m_data;
  int          m_src;
  int          m_last;
  int          m_cnt [NREQ];

  // Outputs captured mid-cycle by the last step, for directed checks.
  logic [3:0]  s_ready;
  logic        s_wen;
  logic [31:0] s_din;
  logic [1:0]  s_gid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_held = 0;
    m_data = '0;
    m_src  = 0;
    m_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  // One clock: drive, compare at the falling edge, advance the model, cross the rising edge.
  task automatic step(input logic rst, input logic [3:0] v, input logic [127:0] d,
                      input logic f);
    int          w;
    bit          accept;
    logic [3:0]  exp_ready;
    bit          exp_wen;
    rst_n     = rst;
    req_valid = v;
    req_data  = d;
    fifo_full = f;
    @(negedge clk);
    w         = pick(v, m_last);
    accept    = (w >= 0) && (!m_held || !f);
    exp_ready = accept ? 4'(1 << w) : 4'b0;
    exp_wen   = m_held && !f;
    s_ready   = req_ready;
    s_wen     = fifo_wen;
    s_din     = fifo_din;
    s_gid     = grant_id;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("fifo_wen", 64'(fifo_wen), 64'(exp_wen));
    chk("fifo_din", 64'(fifo_din), 64'(m_data));
    chk("grant_id", 64'(grant_id), 64'(m_src));
    chk("wen_while_full", 64'(fifo_wen && fifo_full), 64'(0));
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("grant_cnt[%0d]", i), 64'(grant_cnt[i*CNTW +: CNTW]), 64'(m_cnt[i]));
`endif
    if (!rst) begin
      model_reset();
    end else if (accept) begin
      m_held = 1;
      m_data = d[w*32 +: 32];
      m_src  = w;
      m_last = w;
      if (m_cnt[w] < (1 << CNTW) - 1) m_cnt[w]++;
    end else if (exp_wen) begin
      m_held = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mkdata(input int c);
    logic [127:0] r;
    for (int i = 0; i < NREQ; i++) r[i*32 +: 32] = 32'h1000 + 32'(c) * 32'h100 + 32'(i);
    return r;
  endfunction

  typedef struct {
    logic [3:0]  ready;
    logic        wen;
    logic [31:0] din;
    logic [1:0]  gid;
  } vec_t;

  vec_t        tbl [8];
  logic [127:0] d;

  initial begin
    // Full-rate rotation with all requesters valid; din lags its handshake by one cycle.
    tbl[0] = '{4'b0001, 1'b0, 32'h0000, 2'd0};
    tbl[1] = '{4'b0010, 1'b1, 32'h1000, 2'd0};
    tbl[2] = '{4'b0100, 1'b1, 32'h1101, 2'd1};
    tbl[3] = '{4'b1000, 1'b1, 32'h1202, 2'd2};
    tbl[4] = '{4'b0001, 1'b1, 32'h1303, 2'd3};
    tbl[5] = '{4'b0010, 1'b1, 32'h1400, 2'd0};
    tbl[6] = '{4'b0100, 1'b1, 32'h1501, 2'd1};
    tbl[7] = '{4'b1000, 1'b1, 32'h1602, 2'd2};

    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    step(1'b1, 4'b0000, '0, 1'b0);
    chk("reset_wen", 64'(s_wen), 64'(0));
    chk("reset_din", 64'(s_din), 64'(0));
    chk("reset_gid", 64'(s_gid), 64'(0));
    chk("reset_ready", 64'(s_ready), 64'(0));

    for (int c = 0; c < 8; c++) begin
      step(1'b1, 4'b1111, mkdata(c), 1'b0);
      chk($sformatf("tbl%0d_ready", c), 64'(s_ready), 64'(tbl[c].ready));
      chk($sformatf("tbl%0d_wen", c), 64'(s_wen), 64'(tbl[c].wen));
      chk($sformatf("tbl%0d_din", c), 64'(s_din), 64'(tbl[c].din));
      chk($sformatf("tbl%0d_gid", c), 64'(s_gid), 64'(tbl[c].gid));
    end

    // Single requester 2 after reset.
    step(1'b0, 4'b0000, '0, 1'b0);
    d = '0; d[2*32 +: 32] = 32'hA5A5A5A5;
    step(1'b1, 4'b0100, d, 1'b0);
    chk("single_ready", 64'(s_ready), 64'(4'b0100));
    step(1'b1, 4'b0000, '0, 1'b0);
    chk("single_wen", 64'(s_wen), 64'(1));
    chk("single_din", 64'(s_din), 64'(32'hA5A5A5A5));
    chk("single_gid", 64'(s_gid), 64'(2));

    // Stall on full with 0x11 from requester 1 held.
    d = '0; d[1*32 +: 32] = 32'h11;
    step(1'b1, 4'b0010, d, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'b1111, mkdata(c), 1'b1);
      chk("stall_wen", 64'(s_wen), 64'(0));
      chk("stall_ready", 64'(s_ready), 64'(0));
      chk("stall_din", 64'(s_din), 64'(32'h11));
    end
    step(1'b1, 4'b1111, mkdata(9), 1'b0);
    chk("unstall_wen", 64'(s_wen), 64'(1));
    chk("unstall_din", 64'(s_din), 64'(32'h11));
    chk("unstall_ready", 64'(s_ready), 64'(4'b0100));
    step(1'b1, 4'b0000, '0, 1'b0);
    chk("unstall_gid", 64'(s_gid), 64'(2));

    // Pointer wrap from 3 to 0 across idle cycles.
    step(1'b1, 4'b1000, mkdata(3), 1'b0);
    chk("wrap_grant3", 64'(s_ready), 64'(4'b1000));
    repeat (3) step(1'b1, 4'b0000, '0, 1'b0);
    step(1'b1, 4'b1001, mkdata(4), 1'b0);
    chk("wrap_ready", 64'(s_ready), 64'(4'b0001));

    // Reset while a word is held against a full FIFO.
    step(1'b1, 4'b0010, mkdata(5), 1'b0);
    step(1'b1, 4'b1111, mkdata(6), 1'b1);
    step(1'b0, 4'b1111, mkdata(7), 1'b1);
    step(1'b1, 4'b0000, '0, 1'b0);
    chk("rst_drop_wen", 64'(s_wen), 64'(0));
    step(1'b1, 4'b1111, mkdata(8), 1'b0);
    chk("rst_prio_ready", 64'(s_ready), 64'(4'b0001));

`ifdef FIFO_ARB_STATS_EN
    step(1'b0, 4'b0000, '0, 1'b0);
    for (int c = 0; c < 20; c++) step(1'b1, 4'b0001, mkdata(c), 1'b0);
    step(1'b1, 4'b0000, '0, 1'b0);
    chk("sat_cnt0", 64'(grant_cnt[0 +: CNTW]), 64'(15));
    chk("sat_cnt_rest", 64'(grant_cnt[NREQ*CNTW-1:CNTW]), 64'(0));
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 99) != 0), 4'($urandom), d, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
